// File: rtl/mac_seq_ctrl.sv
// Job sequencer for an 8x8->16 multiply-accumulate unit: clears the MAC, streams
// LEN operand pairs into it, drains one cycle, then reports a saturated dot product.
module mac_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_sum,
    input  logic              mac_carry,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    // Handshake: a pair transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on state and count, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               mac_clr_q, mac_clr_d;
    logic [DATA_W-1:0]  mac_a_q, mac_a_d;
    logic [DATA_W-1:0]  mac_b_q, mac_b_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            mac_clr_q <= 1'b1;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            mac_clr_q <= mac_clr_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
            done_q    <= done_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        mac_a_d  = '0;
        mac_b_d  = '0;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                ready    = (cnt_q < len_q);
                sticky_d = sticky_q | mac_carry;
                if (ready && in_valid) begin
                    mac_a_d = in_a;
                    mac_b_d = in_b;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last pair lands in the MAC on this edge; its carry is seen here.
                sticky_d = sticky_q | mac_carry;
                result_d = sticky_d ? {ACC_W{1'b1}} : mac_sum;
                ovf_d    = sticky_d;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear is registered so the MAC zeroes on the edge leaving CLEAR.
        mac_clr_d = (state_d == S_CLEAR);
    end

    assign in_ready = ready;
    assign mac_clr  = mac_clr_q;
    assign mac_a    = mac_a_q;
    assign mac_b    = mac_b_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign ovf      = ovf_q;

endmodule
